// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: baud-select encoding, the
// 16x-oversample divisor table and the receiver state enumeration.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned OS_W       = $clog2(OVERSAMPLE);

  // Oversample tick index of the middle of a bit, and of the last tick of a bit.
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    BAUD_110  = 2'b00,
    BAUD_600  = 2'b01,
    BAUD_2400 = 2'b10,
    BAUD_9600 = 2'b11
  } baud_sel_e;

  // Divisors for the 12 MHz reference clock.
  localparam int unsigned REF_CLK_HZ = 12_000_000;
  localparam int unsigned DIV_110    = 6818;
  localparam int unsigned DIV_600    = 1250;
  localparam int unsigned DIV_2400   = 312;
  localparam int unsigned DIV_9600   = 78;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_e;

  function automatic int unsigned baud_rate(baud_sel_e sel);
    int unsigned rate;
    case (sel)
      BAUD_110:  rate = 110;
      BAUD_600:  rate = 600;
      BAUD_2400: rate = 2400;
      default:   rate = 9600;
    endcase
    return rate;
  endfunction

  // Clocks per oversample tick; the fixed table at the reference clock,
  // otherwise the truncated quotient (which reproduces the table at 12 MHz).
  function automatic int unsigned baud_div(int unsigned clk_hz, baud_sel_e sel);
    int unsigned div;
    if (clk_hz == REF_CLK_HZ) begin
      case (sel)
        BAUD_110:  div = DIV_110;
        BAUD_600:  div = DIV_600;
        BAUD_2400: div = DIV_2400;
        default:   div = DIV_9600;
      endcase
    end else begin
      div = clk_hz / (OVERSAMPLE * baud_rate(sel));
    end
    return div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversample tick generator: one-clock pulse every DIV clocks for the
// selected baud rate. Shared by the receive and transmit stages.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear_i,
  input  baud_sel_e baud_i,
  output logic      tick_o
);

  localparam int unsigned DIV_A = baud_div(CLK_HZ, BAUD_110);
  localparam int unsigned DIV_B = baud_div(CLK_HZ, BAUD_600);
  localparam int unsigned DIV_C = baud_div(CLK_HZ, BAUD_2400);
  localparam int unsigned DIV_D = baud_div(CLK_HZ, BAUD_9600);
  localparam int unsigned CNT_W = (DIV_A > 1) ? $clog2(DIV_A) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d, div_m1;

  // Terminal count for the selected rate.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a default first so no path infers a latch.
    div_m1 = CNT_W'(DIV_D - 1);
    case (baud_i)
      BAUD_110:  div_m1 = CNT_W'(DIV_A - 1);
      BAUD_600:  div_m1 = CNT_W'(DIV_B - 1);
      BAUD_2400: div_m1 = CNT_W'(DIV_C - 1);
      default:   div_m1 = CNT_W'(DIV_D - 1);
    endcase
  end

  assign tick_o = (cnt_q == div_m1);

  // Next count: clear wins, otherwise wrap on the tick.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver (8N1) with a valid/ready output register,
// framing-error and overrun pulses.
module uart_rx_oversample
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 12_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  rx_state_e       state_q, state_d;
  baud_sel_e       baud_q, baud_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, overrun_q, overrun_d;
  logic            armed_q, armed_d;
  logic            rx_meta_q, rx_s_q;
  logic            tick, tick_clr, byte_done, stop_bad;

  uart_baud_tick #(.CLK_HZ(CLK_HZ)) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (tick_clr),
    .baud_i  (baud_q),
    .tick_o  (tick)
  );

  // Frame sequencing: start detect, mid-bit sampling, stop-bit evaluation.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    os_cnt_d  = os_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tick_clr  = 1'b0;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        os_cnt_d  = '0;
        bit_cnt_d = '0;
        if (!rx_s_q && armed_q) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
          baud_d   = baud_sel_e'(baud);
        end
      end
      ST_START: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == OS_MID) begin
            os_cnt_d = '0;
            state_d  = rx_s_q ? ST_IDLE : ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == OS_LAST) begin
            shreg_d   = {rx_s_q, shreg_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = ST_STOP;
            end
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
          if (os_cnt_q == OS_LAST) begin
            state_d   = ST_IDLE;
            byte_done = rx_s_q;
            stop_bad  = !rx_s_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output handshake, overrun detection and post-error re-arm.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    armed_d    = armed_q;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    if (byte_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shreg_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
    if (stop_bad) begin
      armed_d = 1'b0;
    end else if (rx_s_q) begin
      armed_d = 1'b1;
    end
  end

  // State registers, including the two-flop rx synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_q      <= BAUD_110;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      armed_q     <= 1'b1;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= stop_bad;
      overrun_q   <= overrun_d;
      armed_q     <= armed_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_oversample.md
UART_RX_OVERSAMPLE -- requirements
Module: uart_rx_oversample

Interface
REQ-001 Parameter CLK_HZ, default 12000000, system clock frequency in Hz; divisor table (REQ-008) is valid only for this value.
REQ-002 clk  input  1  system clock; one clock domain, all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 baud  input  2  rate select: 00=110, 01=600, 10=2400, 11=9600 bit/s.
REQ-005 rx  input  1  asynchronous serial line; idles high.
REQ-006 rx_data  output  8  received byte, LSB first on the line; stable while rx_valid=1.
REQ-007 Further ports:
- rx_valid  output  1  byte available.
- rx_ready  input  1  downstream accepts the byte.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  one-cycle pulse when a completed byte is dropped.
- busy  output  1  high from start-bit detection until stop-bit evaluation.

Function
REQ-008 A 16x oversample tick is generated by a counter with divisor DIV-1:
- DIV = 6818 / 1250 / 312 / 78 for baud 00 / 01 / 10 / 11.
- Tick asserts one clk when the counter equals DIV-1; the counter then wraps to 0.
REQ-009 The tick counter is cleared, and baud is latched into a 2-bit register, on the cycle start is detected; a baud change mid-frame has no effect until the next frame.
REQ-010 rx passes through a 2-flop synchronizer; all decisions use the second flop (rx_s). rx-to-decision latency is 2 clk.
REQ-011 FSM states: IDLE, START, DATA, STOP.
REQ-012 IDLE->START when rx_s=0 on any clk; busy=1 from the next clk.
REQ-013 START: on the 8th tick (mid-bit), rx_s=0 -> DATA with the oversample count cleared; rx_s=1 -> IDLE (glitch reject; no flags).
REQ-014 DATA: every 16th tick after mid-start, shift rx_s into the shift register LSB-first; after the 8th bit -> STOP.
REQ-015 STOP: on the 16th tick, sample rx_s, then return to IDLE with busy=0.
- rx_s=1: byte is complete.
- rx_s=0: frame_err pulses and the byte is discarded.
REQ-016 Complete byte with rx_valid=0: rx_data loaded and rx_valid=1 on the same clk.
REQ-017 Complete byte with rx_valid=1 and rx_ready=0: new byte dropped, old rx_data kept, overrun pulses.
REQ-018 Complete byte on the same clk that rx_valid=1 and rx_ready=1: new byte loaded, rx_valid stays 1, no overrun.
REQ-019 Handshake: rx_valid clears on the clk after rx_valid&rx_ready when no new byte completes; rx_data never changes while rx_valid=1 except per REQ-018.
REQ-020 After a framing error, IDLE does not re-arm until rx_s has been 1 for at least one clk (break condition yields one frame_err only).

Reset
REQ-021 Reset values while rst=1:
- Outputs: rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- Internal: FSM=IDLE; tick, oversample and bit counters = 0; synchronizer flops = 1.
REQ-022 rst asserted mid-frame abandons the frame; no flags pulse and no byte is delivered.

Structure
REQ-023 A shared package uart_pkg holds:
- baud-select encoding constants;
- DIV table values;
- FSM state enumeration typedef;
- oversample factor 16.
REQ-024 One sub-module uart_baud_tick (latched baud in, tick out) is instantiated; the same sub-module is reused by the transmit stage.

Verification
REQ-025 baud=11, send 0xA5 with a valid stop -> rx_data=0xA5, rx_valid=1 about 10×1250 clk after the start edge; no flags.
REQ-026 baud=11, 0.5-bit (625 clk) low pulse on rx -> returns to IDLE; no rx_valid, no frame_err.
REQ-027 baud=10, send 0x3C with stop bit=0 -> frame_err pulses exactly 1 clk; rx_valid stays 0.
REQ-028 rx_ready=0, send 0x11 then 0x22 -> rx_data=0x11 held, overrun pulses once at the end of the second frame.
REQ-029 baud switched from 11 to 00 mid-frame of 0x5A -> byte received correctly at 9600; the next frame is received at 110 bit/s.
REQ-030 rst pulsed during bit 4 of a frame -> all outputs 0 on the following clk; the next frame 0xFF is received cleanly.
